// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the master's FSM state.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } master_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns valid/ready commands into AR/R or AW/W/B
// traffic and returns the completion on a registered valid/ready response port.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  master_state_t state;
  logic          aw_done;
  logic          w_done;
  logic          aw_hs;
  logic          w_hs;

  assign cmd_ready = (state == IDLE);
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              wstrb   <= cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // The later flag clears override the sets above when both channels finish.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= bresp;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RD_REQ: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= rdata;
            rsp_resp  <= rresp;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Scoreboard bench for axi_lite_master with a delay/error-configurable AXI4-Lite memory slave.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  always #5 aclk = ~aclk;

  axi_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] slv_mem[16];
  int          tests = 0, fails = 0, cyc = 0;
  int          cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
  bit          cfg_err = 1'b0;
  logic [1:0]  cfg_err_resp = 2'b00;
  logic [31:0] cfg_err_rdata = '0;
  bit          rsp_hold = 1'b0, rsp_rand = 1'b0;
  int          rsp_count = 0, rsp_valid_cycles = 0, aw_hi = 0, w_hi = 0, b_hi = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic abort(input string what);
    tests++;
    fails++;
    $display("FAIL timeout_%s: no handshake within cycle budget, expected progress", what);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Memory slave: readies/valids change 1ns after the edge, handshakes noted mid-cycle.
  initial begin
    bit aw_h, w_h, b_h, ar_h, r_h;
    bit got_aw, got_w, got_ar, wr_applied;
    int aw_c, w_c, b_c, ar_c, r_c;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    got_aw = 0; got_w = 0; got_ar = 0; wr_applied = 0;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_wstrb = '0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    forever begin
      @(negedge aclk);
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      b_h  = bvalid && bready;
      ar_h = arvalid && arready;
      r_h  = rvalid && rready;
      if (aw_h) s_awaddr = awaddr;
      if (w_h) begin s_wdata = wdata; s_wstrb = wstrb; end
      if (ar_h) s_araddr = araddr;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        got_aw = 0; got_w = 0; got_ar = 0; wr_applied = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      end else begin
        if (aw_h) got_aw = 1;
        if (w_h) got_w = 1;
        if (ar_h) got_ar = 1;
        if (b_h) begin got_aw = 0; got_w = 0; wr_applied = 0; b_c = 0; bvalid = 0; end
        if (r_h) begin got_ar = 0; r_c = 0; rvalid = 0; end
        if (awvalid && !got_aw) begin awready = (aw_c >= cfg_aw_d); aw_c++; end
        else begin awready = 0; aw_c = 0; end
        if (wvalid && !got_w) begin wready = (w_c >= cfg_w_d); w_c++; end
        else begin wready = 0; w_c = 0; end
        if (arvalid && !got_ar) begin arready = (ar_c >= cfg_ar_d); ar_c++; end
        else begin arready = 0; ar_c = 0; end
        if (got_aw && got_w && !bvalid) begin
          if (!wr_applied) begin
            wr_applied = 1;
            if (!cfg_err)
              for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) slv_mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
          end
          if (b_c >= cfg_b_d) begin bvalid = 1; bresp = cfg_err ? cfg_err_resp : 2'b00; end
          else b_c++;
        end
        if (got_ar && !rvalid) begin
          if (r_c >= cfg_r_d) begin
            rvalid = 1;
            rdata  = cfg_err ? cfg_err_rdata : slv_mem[s_araddr[5:2]];
            rresp  = cfg_err ? cfg_err_resp : 2'b00;
          end else r_c++;
        end
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      rsp_ready = rsp_hold ? 1'b0 : (rsp_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Monitor: scoreboard pops plus protocol checks, all sampled mid-cycle.
  initial begin
    exp_t        e;
    bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
    logic [3:0]  p_wstrb;
    logic [1:0]  p_resp;
    bit          p_write;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        p_awv = 0; p_wv = 0; p_arv = 0; p_rv = 0;
      end else begin
        if (rsp_valid) rsp_valid_cycles++;
        if (awvalid) aw_hi++;
        if (wvalid) w_hi++;
        if (bready) b_hi++;
        if (rsp_valid && rsp_ready) begin
          rsp_count++;
          chk("rsp_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_write", rsp_write, e.wr);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
          end
        end
        if (p_awv && !p_awr) chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (p_wv && !p_wr) chk("w_stable", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
        if (p_arv && !p_arr) chk("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
        if (p_rv && !p_rr)
          chk("rsp_stable", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, p_write, p_resp, p_rdata});
        if (arvalid || awvalid || wvalid) chk("ar_aw_overlap", arvalid && (awvalid || wvalid), 0);
        if (rsp_valid) chk("rsp_exclusive", {cmd_ready, awvalid, wvalid, arvalid, rready, bready}, 6'b0);
        p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
        p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
        p_arv = arvalid; p_arr = arready; p_araddr = araddr;
        p_rv = rsp_valid; p_rr = rsp_ready; p_write = rsp_write; p_resp = rsp_resp; p_rdata = rsp_rdata;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, {arvalid, awvalid, wvalid, rready, bready, rsp_valid, rsp_write}, 7'b0);
    chk({tag, "_payload"}, |{araddr, awaddr, wdata, wstrb, rsp_rdata, rsp_resp}, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int d_aw, input int d_w, input int d_b,
                       input int d_ar, input int d_r, input bit err, input logic [1:0] eresp,
                       input logic [31:0] erdata, output int acc);
    exp_t        e;
    logic [31:0] mask;
    int          n;
    n = 0;
    @(negedge aclk);
    while (!cmd_ready) begin
      n++;
      if (n > 300) abort("cmd_ready");
      @(negedge aclk);
    end
    cfg_aw_d = d_aw; cfg_w_d = d_w; cfg_b_d = d_b; cfg_ar_d = d_ar; cfg_r_d = d_r;
    cfg_err = err; cfg_err_resp = eresp; cfg_err_rdata = erdata;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    e.wr = wr;
    e.resp = err ? eresp : OKAY;
    if (wr) begin
      e.rdata = '0;
      if (!err) begin
        mask = '0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        ref_mem[addr[5:2]] = (ref_mem[addr[5:2]] & ~mask) | (data & mask);
      end
    end else begin
      e.rdata = err ? erdata : ref_mem[addr[5:2]];
    end
    exp_q.push_back(e);
    @(posedge aclk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    @(negedge aclk);
    chk("first_valids", {awvalid, wvalid, arvalid}, wr ? 3'b110 : 3'b001);
    if (wr) begin
      chk("first_awaddr", awaddr, addr);
      chk("first_wpayload", {wstrb, wdata}, {strb, data});
    end else begin
      chk("first_araddr", araddr, addr);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge aclk);
      n++;
      if (n > 500) abort("rsp");
    end
  endtask

  task automatic wr_ok(input logic [31:0] addr, input logic [31:0] data);
    int acc;
    issue(1'b1, addr, data, 4'hF, 0, 0, 0, 0, 0, 1'b0, 2'b00, '0, acc);
  endtask

  task automatic rd_ok(input logic [31:0] addr);
    int acc;
    issue(1'b0, addr, '0, 4'h0, 0, 0, 0, 0, 0, 1'b0, 2'b00, '0, acc);
  endtask

  initial begin
    int          acc[4];
    int          base, n, tmp;
    bit          wr, err;
    logic [31:0] a, d, ed;
    logic [3:0]  s;
    logic [1:0]  er;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h0101_0101 * i;
      slv_mem[i] = 32'h0101_0101 * i;
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
    repeat (3) @(negedge aclk);
    chk_reset("reset");
    cmd_valid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("post_reset_idle", {awvalid, arvalid, cmd_ready}, 3'b001);

    wr_ok(32'h10, 32'hDEAD_BEEF);
    rd_ok(32'h10);
    wait_done();

    // Skewed write: W accepted at once, AW after three wait cycles.
    aw_hi = 0; w_hi = 0; b_hi = 0; base = rsp_count;
    issue(1'b1, 32'h14, 32'hA5A5_0F0F, 4'b0101, 3, 0, 0, 0, 0, 1'b0, 2'b00, '0, tmp);
    wait_done();
    chk("skew_aw_cycles", aw_hi, 4);
    chk("skew_w_cycles", w_hi, 1);
    chk("skew_bready_cycles", b_hi, 1);
    chk("skew_rsp_count", rsp_count - base, 1);
    rd_ok(32'h14);

    issue(1'b1, 32'h18, 32'h1111_2222, 4'hF, 0, 0, 1, 0, 0, 1'b1, SLVERR, '0, tmp);
    issue(1'b0, 32'h18, '0, 4'h0, 0, 0, 0, 1, 2, 1'b1, DECERR, 32'h1234_5678, tmp);
    rd_ok(32'h18);
    wait_done();

    rsp_hold = 1'b1;
    wr_ok(32'h24, 32'hCAFE_F00D);
    n = 0;
    while (!rsp_valid) begin
      @(negedge aclk);
      n++;
      if (n > 50) abort("bp_rsp_valid");
    end
    repeat (5) begin
      @(negedge aclk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_hold = 1'b0;
    wait_done();

    issue(1'b0, 32'h10, '0, 4'h0, 0, 0, 0, 0, 6, 1'b0, 2'b00, '0, tmp);
    n = 0;
    while (!rready) begin
      @(negedge aclk);
      n++;
      if (n > 50) abort("rready");
    end
    #2 aresetn = 1'b0;
    #1 chk_reset("midrst");
    exp_q.delete();
    base = rsp_valid_cycles;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (10) @(negedge aclk);
    chk("midrst_no_rsp", rsp_valid_cycles - base, 0);
    rd_ok(32'h10);
    wait_done();

    // Zero-wait back-to-back commands should be accepted every 4 cycles.
    for (int i = 0; i < 4; i++)
      issue(i % 2 == 0, 32'h30 + 32'(i * 4), 32'h5500_0000 + 32'(i), 4'hF,
            0, 0, 0, 0, 0, 1'b0, 2'b00, '0, acc[i]);
    wait_done();
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 4);

    rsp_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 15)) << 2;
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      err = ($urandom_range(0, 7) == 0);
      er  = 2'($urandom_range(1, 3));
      ed  = $urandom;
      issue(wr, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), err, er, ed, tmp);
    end
    wait_done();
    rsp_rand = 1'b0;
    for (int i = 0; i < 16; i++) rd_ok(32'(i * 4));
    wait_done();
    repeat (3) @(negedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
